// File: rtl/sdram_demo_pkg.sv
// Shared types and constants for the SDRAM demo RAM tester.
// Holds the pass FSM encoding, pattern step default and counter widths.
package sdram_demo_pkg;

    localparam int unsigned DefAddrW   = 14;
    localparam int unsigned DefDataW   = 32;
    localparam logic [31:0] DefPatStep = 32'h9E3779B9;
    localparam int unsigned ErrCntW    = 16;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StRead,
        StDrain,
        StFinish
    } state_e;

    // Word counter must hold 0..2^addr_w inclusive.
    function automatic int unsigned len_width(int unsigned addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/sdram_demo_pat_gen.sv
// Address/pattern accumulator: load captures base and seed, step advances both.
// Shared by the fill and check passes so both walk the identical sequence.
module sdram_demo_pat_gen
    import sdram_demo_pkg::*;
#(
    parameter int unsigned          ADDR_W   = DefAddrW,
    parameter int unsigned          DATA_W   = DefDataW,
    parameter logic [DATA_W-1:0]    PAT_STEP = DATA_W'(DefPatStep)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] base,
    input  logic [DATA_W-1:0] seed,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] pat
);

    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] pat_q;

    // Address wraps naturally at 2^ADDR_W; pattern wraps at 2^DATA_W.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= '0;
            pat_q  <= '0;
        end else if (load) begin
            addr_q <= base;
            pat_q  <= seed;
        end else if (step) begin
            addr_q <= addr_q + ADDR_W'(1);
            pat_q  <= pat_q + PAT_STEP;
        end
    end

    assign addr = addr_q;
    assign pat  = pat_q;

endmodule

// File: rtl/sdram_demo_ram_tester.sv
// RAM pattern tester: fills a window of words with an arithmetic pattern or
// reads it back, counting mismatches against the same pattern.
module sdram_demo_ram_tester
    import sdram_demo_pkg::*;
#(
    parameter int unsigned          ADDR_W   = DefAddrW,
    parameter int unsigned          DATA_W   = DefDataW,
    parameter logic [DATA_W-1:0]    PAT_STEP = DATA_W'(DefPatStep)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  mode,
    input  logic [ADDR_W-1:0]     base,
    input  logic [ADDR_W:0]       len,
    input  logic [DATA_W-1:0]     seed,
    output logic [ADDR_W-1:0]     ram_address,
    output logic [DATA_W/8-1:0]   ram_byteenable,
    output logic                  ram_chipselect,
    output logic                  ram_write,
    output logic [DATA_W-1:0]     ram_writedata,
    output logic                  ram_clken,
    input  logic [DATA_W-1:0]     ram_readdata,
    output logic                  busy,
    output logic                  done,
    output logic [ErrCntW-1:0]    err_count,
    output logic [ADDR_W-1:0]     first_err_addr,
    output logic                  pass
);

    localparam int unsigned      LenW   = len_width(ADDR_W);
    localparam logic [LenW-1:0]  CntOne = LenW'(1);

    state_e              state_q, state_d;
    logic [LenW-1:0]     cnt_q, cnt_d;
    logic                mode_q;
    logic                accept;
    logic                pat_load;
    logic                pat_step;
    logic [ADDR_W-1:0]   pat_addr;
    logic [DATA_W-1:0]   pat_data;
    logic                cmp_valid_q;
    logic [DATA_W-1:0]   exp_data_q;
    logic [ADDR_W-1:0]   exp_addr_q;
    logic [ErrCntW-1:0]  err_q;
    logic [ADDR_W-1:0]   first_err_q;
    logic                pass_q;
    logic                mismatch;

    sdram_demo_pat_gen #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .PAT_STEP (PAT_STEP)
    ) u_pat_gen (
        .clk   (clk),
        .reset (reset),
        .load  (pat_load),
        .step  (pat_step),
        .base  (base),
        .seed  (seed),
        .addr  (pat_addr),
        .pat   (pat_data)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept   = 1'b0;
        pat_load = 1'b0;
        pat_step = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    accept   = 1'b1;
                    pat_load = 1'b1;
                    cnt_d    = len;
                    if (len == '0) begin
                        state_d = StFinish;
                    end else if (mode) begin
                        state_d = StRead;
                    end else begin
                        state_d = StWrite;
                    end
                end
            end
            StWrite, StRead: begin
                pat_step = 1'b1;
                cnt_d    = cnt_q - CntOne;
                if (cnt_q == CntOne) begin
                    state_d = (state_q == StWrite) ? StFinish : StDrain;
                end
            end
            StDrain:  state_d = StFinish;
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Read data returns one cycle after its address, so compare against the
    // pattern registered alongside that address.
    assign mismatch = cmp_valid_q && (ram_readdata != exp_data_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            mode_q      <= 1'b0;
            cmp_valid_q <= 1'b0;
            exp_data_q  <= '0;
            exp_addr_q  <= '0;
            err_q       <= '0;
            first_err_q <= '0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmp_valid_q <= (state_q == StRead);
            exp_data_q  <= pat_data;
            exp_addr_q  <= pat_addr;
            if (accept) begin
                mode_q      <= mode;
                err_q       <= '0;
                first_err_q <= '0;
                pass_q      <= 1'b0;
            end else if (mismatch) begin
                if (err_q != '1) begin
                    err_q <= err_q + ErrCntW'(1);
                end
                if (err_q == '0) begin
                    first_err_q <= exp_addr_q;
                end
            end
            if (state_q == StFinish) begin
                pass_q <= mode_q && (err_q == '0);
            end
        end
    end

    always_comb begin
        ram_chipselect = 1'b0;
        ram_write      = 1'b0;
        ram_address    = '0;
        ram_writedata  = '0;
        busy           = 1'b0;
        done           = 1'b0;
        unique case (state_q)
            StWrite: begin
                ram_chipselect = 1'b1;
                ram_write      = 1'b1;
                ram_address    = pat_addr;
                ram_writedata  = pat_data;
                busy           = 1'b1;
            end
            StRead: begin
                ram_chipselect = 1'b1;
                ram_address    = pat_addr;
                busy           = 1'b1;
            end
            StDrain:  busy = 1'b1;
            StFinish: done = 1'b1;
            default: ;
        endcase
    end

    assign ram_byteenable = '1;
    assign ram_clken      = 1'b1;
    assign err_count      = err_q;
    assign first_err_addr = first_err_q;
    assign pass           = pass_q;

endmodule

// File: tb/tb_sdram_demo_ram_tester.sv
// Bench for sdram_demo_ram_tester: behavioural RAM, access monitor and an
// arithmetic pattern model that predicts traces, latency and error results.
module tb_sdram_demo_ram_tester;

    localparam int unsigned AW    = 14;
    localparam int unsigned DW    = 32;
    localparam int unsigned Words = 1 << AW;
    localparam logic [31:0] Step  = 32'h9E3779B9;

    logic          clk;
    logic          reset;
    logic          start;
    logic          mode;
    logic [AW-1:0] base;
    logic [AW:0]   len;
    logic [DW-1:0] seed;
    logic [AW-1:0] ram_address;
    logic [3:0]    ram_byteenable;
    logic          ram_chipselect;
    logic          ram_write;
    logic [DW-1:0] ram_writedata;
    logic          ram_clken;
    logic [DW-1:0] ram_readdata;
    logic          busy;
    logic          done;
    logic [15:0]   err_count;
    logic [AW-1:0] first_err_addr;
    logic          pass;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem [Words];
    logic          tr_wr   [$];
    logic [AW-1:0] tr_addr [$];
    logic [DW-1:0] tr_wd   [$];

    sdram_demo_ram_tester dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .mode           (mode),
        .base           (base),
        .len            (len),
        .seed           (seed),
        .ram_address    (ram_address),
        .ram_byteenable (ram_byteenable),
        .ram_chipselect (ram_chipselect),
        .ram_write      (ram_write),
        .ram_writedata  (ram_writedata),
        .ram_clken      (ram_clken),
        .ram_readdata   (ram_readdata),
        .busy           (busy),
        .done           (done),
        .err_count      (err_count),
        .first_err_addr (first_err_addr),
        .pass           (pass)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM with one-cycle read latency.
    always @(posedge clk) begin
        if (ram_chipselect) begin
            if (ram_write) mem[ram_address] <= ram_writedata;
            else           ram_readdata     <= mem[ram_address];
        end
    end

    always @(negedge clk) begin
        if (ram_chipselect === 1'b1) begin
            tr_wr.push_back(ram_write);
            tr_addr.push_back(ram_address);
            tr_wd.push_back(ram_writedata);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat_of(input logic [DW-1:0] s, input int i);
        return s + 32'(i) * Step;
    endfunction

    task automatic do_pass(input logic m, input logic [AW-1:0] b, input int n,
                           input logic [DW-1:0] s, input string tag);
        int            exp_err;
        logic [AW-1:0] exp_first;
        logic [AW-1:0] a;
        int            cyc;
        int            busy_cnt;
        int            bad;
        int            exp_lat;

        // Expected check outcome straight from the RAM contents and pattern rule.
        exp_err   = 0;
        exp_first = '0;
        if (m) begin
            for (int i = 0; i < n; i++) begin
                a = b + AW'(i);
                if (mem[a] !== pat_of(s, i)) begin
                    if (exp_err == 0) exp_first = a;
                    exp_err++;
                end
            end
        end
        tr_wr.delete();
        tr_addr.delete();
        tr_wd.delete();

        @(posedge clk); #1;
        start = 1'b1; mode = m; base = b; len = (AW+1)'(n); seed = s;
        @(posedge clk); #1;
        start = 1'b0; mode = 1'($urandom); base = AW'($urandom);
        len = (AW+1)'($urandom); seed = $urandom;

        cyc = 0;
        busy_cnt = 0;
        while (done !== 1'b1 && cyc < n + 10) begin
            if (busy === 1'b1) busy_cnt++;
            @(posedge clk); #1;
            cyc++;
        end
        exp_lat = (n == 0) ? 2 : (m ? n + 3 : n + 2);
        check({tag, " done seen"}, done, 1'b1);
        check({tag, " latency"}, cyc + 2, exp_lat);
        check({tag, " busy cycles"}, busy_cnt, (n == 0) ? 0 : (m ? n + 1 : n));
        check({tag, " busy at done"}, busy, 1'b0);
        @(posedge clk); #1;
        check({tag, " done width"}, done, 1'b0);
        check({tag, " idle cs"}, {ram_chipselect, ram_write, ram_writedata}, '0);
        check({tag, " err_count"}, err_count, exp_err);
        if (exp_err != 0) check({tag, " first_err"}, first_err_addr, exp_first);
        check({tag, " pass"}, pass, m && (exp_err == 0));

        bad = 0;
        check({tag, " trace len"}, tr_addr.size(), n);
        for (int i = 0; i < tr_addr.size() && i < n; i++) begin
            a = b + AW'(i);
            if (tr_wr[i] !== !m) bad++;
            if (tr_addr[i] !== a) bad++;
            if (!m && tr_wd[i] !== pat_of(s, i)) bad++;
        end
        check({tag, " trace content"}, bad, 0);
    endtask

    initial begin
        logic [DW-1:0] s;
        logic [DW-1:0] v;
        logic [AW-1:0] b;
        int            n;
        int            k;
        int            stray;

        for (int i = 0; i < Words; i++) mem[i] = '0;
        ram_readdata = '0;
        reset = 1'b1; start = 1'b0; mode = 1'b0; base = '0; len = '0; seed = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy/done/pass", {busy, done, pass}, 3'b000);
        check("reset err_count", err_count, 16'h0);
        check("reset first_err", first_err_addr, 14'h0);
        check("reset ram ctl", {ram_chipselect, ram_write}, 2'b00);
        check("reset ram addr", ram_address, 14'h0);
        check("reset ram wdata", ram_writedata, 32'h0);
        check("byteenable/clken", {ram_byteenable, ram_clken}, 5'b11111);
        reset = 1'b0;

        // Basic fill then check.
        do_pass(1'b0, 14'd0, 16, 32'h0, "fill16");
        v = (tr_wd.size() > 2) ? tr_wd[1] : 32'h0;
        check("fill16 word1", v, 32'h9E3779B9);
        v = (tr_wd.size() > 2) ? tr_wd[2] : 32'h0;
        check("fill16 word2", v, 32'h3C6EF372);
        do_pass(1'b1, 14'd0, 16, 32'h0, "check16");
        check("check16 pass", pass, 1'b1);

        // Seed mismatch: every word wrong.
        do_pass(1'b0, 14'd0, 8, 32'h1, "fill8s1");
        do_pass(1'b1, 14'd0, 8, 32'h2, "check8s2");
        check("seedmm err_count", err_count, 16'd8);
        check("seedmm first_err", first_err_addr, 14'd0);
        check("seedmm pass", pass, 1'b0);

        // Address wrap.
        do_pass(1'b0, 14'd16380, 8, 32'hCAFE0000, "fillwrap");
        do_pass(1'b1, 14'd16380, 8, 32'hCAFE0000, "checkwrap");
        v = (tr_addr.size() > 4) ? 32'(tr_addr[4]) : 32'hFFFF;
        check("wrap addr4", v, 32'h0);
        check("wrap pass", pass, 1'b1);

        // Zero-length pass issues no access.
        do_pass(1'b0, 14'd77, 0, 32'h1234, "len0");

        // Single corrupted word.
        s = $urandom;
        do_pass(1'b0, 14'd0, 16, s, "fillcorr");
        mem[5] = mem[5] ^ 32'h0001_0000;
        do_pass(1'b1, 14'd0, 16, s, "checkcorr");
        check("corr err_count", err_count, 16'd1);
        check("corr first_err", first_err_addr, 14'd5);

        // Reset while word 3 of a fill is on the bus.
        @(posedge clk); #1;
        start = 1'b1; mode = 1'b0; base = 14'd100; len = 15'd16; seed = $urandom;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("abort word3 addr", {ram_chipselect, ram_address}, {1'b1, 14'd103});
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort cs after reset", {ram_chipselect, ram_write}, 2'b00);
        check("abort busy", busy, 1'b0);
        stray = 0;
        repeat (6) begin
            if (done !== 1'b0 || ram_chipselect !== 1'b0) stray++;
            @(posedge clk); #1;
        end
        check("abort quiet", stray, 0);
        do_pass(1'b0, 14'd200, 12, 32'h55AA55AA, "postabort fill");
        do_pass(1'b1, 14'd200, 12, 32'h55AA55AA, "postabort check");

        // Randomised fill/corrupt/check rounds.
        for (int r = 0; r < 4; r++) begin
            b = AW'($urandom);
            n = $urandom_range(1, 48);
            s = $urandom;
            do_pass(1'b0, b, n, s, $sformatf("rnd%0d fill", r));
            k = $urandom_range(0, 3);
            for (int j = 0; j < k; j++) begin
                v = 32'($urandom_range(1, 32'hFFFF));
                mem[b + AW'($urandom_range(0, n - 1))] ^= v;
            end
            do_pass(1'b1, b, n, s, $sformatf("rnd%0d check", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_demo_ram_tester.md
SDRAM_DEMO_RAM_TESTER -- requirements
Module: sdram_demo_ram_tester

Interface
REQ-001 Parameter ADDR_W, default 14, RAM word-address width.
REQ-002 Parameter DATA_W, default 32, RAM data width; byte lanes = DATA_W/8.
REQ-003 Parameter PAT_STEP, default 32'h9E3779B9, pattern increment per word.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle request; sampled only in IDLE.
REQ-007 mode  in  1  0 = fill (write pass), 1 = check (read-compare pass); captured at start.
REQ-008 base  in  ADDR_W  first word address; captured at start.
REQ-009 len  in  ADDR_W+1  word count, 0..2^ADDR_W; captured at start.
REQ-010 seed  in  DATA_W  pattern value for word 0; captured at start.
REQ-011 ram_address  out  ADDR_W  word address to RAM.
REQ-012 ram_byteenable  out  DATA_W/8  byte enables; always all ones.
REQ-013 ram_chipselect, ram_write  out  1 each  access qualifiers.
REQ-014 ram_writedata  out  DATA_W  write data.
REQ-015 ram_clken  out  1  RAM clock enable; constant 1.
REQ-016 ram_readdata  in  DATA_W  RAM read data, valid the cycle after its address is presented.
REQ-017 busy  out  1  high from the cycle after an accepted start until done.
REQ-018 done  out  1  one-cycle pulse at end of pass.
REQ-019 err_count  out  16  mismatches in last check pass, saturating at 16'hFFFF.
REQ-020 first_err_addr  out  ADDR_W  address of first mismatch; valid when err_count != 0.
REQ-021 pass  out  1  high when last completed pass was a check with err_count == 0.

Function
REQ-022 States: IDLE, WRITE, READ, DRAIN, FINISH.
REQ-023 IDLE + start + len==0 -> FINISH; no RAM access issued.
REQ-024 IDLE + start + mode==0 + len!=0 -> WRITE; mode==1 -> READ; err_count, first_err_addr and pass clear on the same edge.
REQ-025 WRITE: one word per cycle, chipselect=write=1, address = (base+i) mod 2^ADDR_W, data = seed + i*PAT_STEP (mod 2^DATA_W), built by running accumulator, i = 0..len-1.
REQ-026 WRITE -> FINISH after word len-1 is issued; write burst occupies exactly len cycles.
REQ-027 READ: chipselect=1, write=0, one address per cycle with the same address/pattern sequence; READ -> DRAIN after address len-1.
REQ-028 Compare ram_readdata to expected pattern delayed one cycle; last compare occurs in DRAIN (1 cycle), then -> FINISH.
REQ-029 Mismatch: err_count increments (saturating); first_err_addr loads only when err_count was 0.
REQ-030 FINISH: done=1 for exactly one cycle, pass updated, -> IDLE; busy low in that cycle.
REQ-031 Address wraps from 2^ADDR_W-1 to 0 without error or stall.
REQ-032 start while not IDLE is ignored; inputs other than start are don't-care outside the capture cycle.
REQ-033 Outside WRITE/READ, ram_chipselect=ram_write=0 and ram_writedata=0.
REQ-034 Throughput: fill of N words completes (done) N+2 cycles after start; check N+3 cycles.

Reset
REQ-035 On reset: state IDLE, busy=0, done=0, pass=0, err_count=0, first_err_addr=0, ram_chipselect=ram_write=0, ram_address=0, ram_writedata=0.
REQ-036 Reset mid-pass aborts on that edge; no further RAM access, no done pulse.

Structure
REQ-037 State enum, PAT_STEP default and counter widths reside in shared package sdram_demo_pkg.
REQ-038 One sub-module, sdram_demo_pat_gen (address/pattern accumulator with load and step), shared by WRITE and READ paths.

Verification
REQ-039 Fill base=0, len=16, seed=0 then check -> writes 0, 9E3779B9, 3C6EF372,...; check pass=1, err_count=0, done each pass.
REQ-040 Fill len=8 seed=1, check seed=2 -> err_count=8, first_err_addr=0, pass=0.
REQ-041 base=16380, len=8 -> addresses 16380..16383,0..3 in order, check pass=1.
REQ-042 len=0 -> done 2 cycles after start, no chipselect ever asserted.
REQ-043 Corrupt word at address 5 via backdoor after fill len=16 -> err_count=1, first_err_addr=5.
REQ-044 Assert reset during WRITE at i=3 -> no access next cycle, busy=0, no done; subsequent start runs normally.
